// File: rtl/mult_simd_pkg.sv
// Shared definitions for the SIMD multiplier job sequencer.
//   - multiplier mode encodings (16x16 and the three packed sum modes)
//   - sequencer state enum
//   - width of the raw packed multiplier output {carry, result_1, result_0}
package mult_simd_pkg;

    localparam logic [1:0] MODE_16X16   = 2'b00;
    localparam logic [1:0] MODE_SUM_8X8 = 2'b01;
    localparam logic [1:0] MODE_SUM_4X4 = 2'b10;
    localparam logic [1:0] MODE_SUM_2X2 = 2'b11;

    localparam int RAW_W = 72;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/mult_simd_acc_unit.sv
// Dot-product accumulator for the 16x16 mode.
// Rebuilds the 32-bit product from the two multiplier result words,
// extends it to ACC_W (sign-extended when either operand is signed) and
// accumulates it on each committed beat. The accumulator wraps mod 2^ACC_W.
// Ports:
//   clk, reset         clock, async active-high reset
//   clear              zero the accumulator (start of a new job)
//   commit             beat in the issue stage commits this cycle
//   mode               job mode; only MODE_16X16 accumulates
//   ext_sign           sign-extend the product (a_sign | b_sign)
//   result_0/result_1  multiplier result words for the beat in the issue stage
//   acc_sum            accumulator plus this beat's product (value after commit)
module mult_simd_acc_unit
    import mult_simd_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             commit,
    input  logic [1:0]       mode,
    input  logic             ext_sign,
    input  logic [31:0]      result_0,
    input  logic [31:0]      result_1,
    output logic [ACC_W-1:0] acc_sum
);

    logic [ACC_W-1:0] acc_q;
    logic [31:0]      prod;
    logic [ACC_W-1:0] prod_ext;

    always_comb begin
        prod     = result_0 + result_1;
        prod_ext = ext_sign ? ACC_W'($signed(prod)) : ACC_W'(prod);
        acc_sum  = acc_q + prod_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (commit && (mode == MODE_16X16)) begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/mult_simd_job_sequencer.sv
// Job-level controller for the 2x2-cluster 16-bit SIMD multiplier.
// Takes one job configuration, streams operand beats through a registered
// issue stage into the external combinational multiplier, then either
// accumulates a dot product (16x16) or forwards each beat's packed outputs.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; a producer holds its payload stable while valid & !ready, and
// ready never depends combinationally on the same interface's valid.
//
// Ports:
//   cfg_*             job configuration (mode, signedness, beat count)
//   in_*              operand beat stream
//   mul_*  (out)      registered operands/config to the multiplier
//   mul_result_*, mul_carry (in)  multiplier results for the beat in s1
//   out_*             single-entry output register (acc, raw, last)
//   busy              sequencer not idle
//   dbg_state         current FSM state
module mult_simd_job_sequencer
    import mult_simd_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_a_sign,
    input  logic             cfg_b_sign,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_a_sign,
    output logic             mul_b_sign,
    output logic [1:0]       mul_mode,
    input  logic [31:0]      mul_result_0,
    input  logic [31:0]      mul_result_1,
    input  logic [7:0]       mul_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [RAW_W-1:0] out_raw,
    output logic             out_last,
    output logic             busy,
    output state_t           dbg_state
);

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic             a_sign_q, b_sign_q;
    logic [LEN_W-1:0] remaining_q;
    logic             s1_valid_q, s1_last_q;

    logic             is_acc_mode;
    logic             cfg_accept, beat_accept;
    logic             s1_commit;
    logic             out_load_beat, out_load_empty, out_take;
    logic [ACC_W-1:0] acc_sum;

    always_comb begin
        is_acc_mode = (mode_q == MODE_16X16);
        cfg_ready   = (state_q == IDLE);
        cfg_accept  = cfg_valid & cfg_ready;
        // Non-final 16x16 beats never touch the output register, so they
        // may commit even while a previous result is still waiting.
        s1_commit   = s1_valid_q & (!out_valid | out_ready | (is_acc_mode & !s1_last_q));
        in_ready    = (state_q == RUN) && (remaining_q != '0) && (!s1_valid_q || s1_commit);
        beat_accept = in_valid & in_ready;
        out_load_beat  = s1_commit & (!is_acc_mode | s1_last_q);
        out_load_empty = cfg_accept && (cfg_len == '0) && (cfg_mode == MODE_16X16);
        out_take       = out_valid & out_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_accept) begin
                    state_d = out_load_empty ? HOLD : RUN;
                end
            end
            RUN: begin
                if ((remaining_q == '0) && (!s1_valid_q || s1_commit)) begin
                    state_d = is_acc_mode ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (out_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job configuration and beat countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_16X16;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            remaining_q <= '0;
        end else if (cfg_accept) begin
            mode_q      <= cfg_mode;
            a_sign_q    <= cfg_a_sign;
            b_sign_q    <= cfg_b_sign;
            remaining_q <= cfg_len;
        end else if (beat_accept) begin
            remaining_q <= remaining_q - LEN_W'(1);
        end
    end

    // Issue stage: operands held in front of the multiplier for one beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else if (beat_accept) begin
            s1_valid_q <= 1'b1;
            s1_last_q  <= (remaining_q == LEN_W'(1));
            mul_a      <= in_a;
            mul_b      <= in_b;
        end else if (s1_commit) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Output register; a new load may coincide with the handshake of the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_acc   <= '0;
            out_raw   <= '0;
        end else if (out_load_beat) begin
            out_valid <= 1'b1;
            out_last  <= s1_last_q;
            if (is_acc_mode) begin
                out_acc <= acc_sum;
                out_raw <= '0;
            end else begin
                out_acc <= '0;
                out_raw <= {mul_carry, mul_result_1, mul_result_0};
            end
        end else if (out_load_empty) begin
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            out_acc   <= '0;
            out_raw   <= '0;
        end else if (out_take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    mult_simd_acc_unit #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (cfg_accept),
        .commit   (s1_commit),
        .mode     (mode_q),
        .ext_sign (a_sign_q | b_sign_q),
        .result_0 (mul_result_0),
        .result_1 (mul_result_1),
        .acc_sum  (acc_sum)
    );

    assign mul_mode   = mode_q;
    assign mul_a_sign = a_sign_q;
    assign mul_b_sign = b_sign_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_simd_job_sequencer.sv
// Bench for mult_simd_job_sequencer. Two instances share all inputs:
// dut (ACC_W=48) and dut32 (ACC_W=32, for accumulator wrap). A behavioural
// multiplier closes the loop for each instance.
module tb_mult_simd_job_sequencer;
    import mult_simd_pkg::*;

    localparam int W = 1 + RAW_W + 48;
    localparam int BUDGET = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_a_sign, cfg_b_sign;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        out_ready;

    logic        cfg_ready, in_ready, mul_a_sign, mul_b_sign, out_valid, out_last, busy;
    logic [31:0] mul_a, mul_b, mul_result_0, mul_result_1;
    logic [7:0]  mul_carry;
    logic [1:0]  mul_mode;
    logic [47:0] out_acc;
    logic [RAW_W-1:0] out_raw;
    state_t      dbg_state;

    logic        w_cfg_ready, w_in_ready, w_mul_a_sign, w_mul_b_sign, w_out_valid, w_out_last, w_busy;
    logic [31:0] w_mul_a, w_mul_b, w_mul_result_0, w_mul_result_1;
    logic [7:0]  w_mul_carry;
    logic [1:0]  w_mul_mode;
    logic [31:0] w_out_acc;
    logic [RAW_W-1:0] w_out_raw;
    state_t      w_dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] beat_a[0:15];
    logic [31:0] beat_b[0:15];
    bit rand_done;

    always #5 clk = ~clk;

    // ---------------- multiplier stand-in and reference arithmetic ----------------
    function automatic logic [31:0] prod16(logic [31:0] a, logic [31:0] b, logic as, logic bs);
        logic signed [16:0] sa, sb;
        logic signed [33:0] p;
        sa = {as & a[15], a[15:0]};
        sb = {bs & b[15], b[15:0]};
        p  = sa * sb;
        return p[31:0];
    endfunction

    function automatic logic [47:0] ext48(logic [31:0] p, logic sgn);
        return sgn ? {{16{p[31]}}, p} : {16'h0, p};
    endfunction

    // 16x16 splits the product across both words so the DUT must add them.
    function automatic logic [RAW_W-1:0] mul_model(logic [31:0] a, logic [31:0] b,
                                                   logic as, logic bs, logic [1:0] mode);
        logic [31:0] p, r0, r1;
        if (mode == MODE_16X16) begin
            p  = prod16(a, b, as, bs);
            r1 = {16'h0, p[15:0]};
            r0 = p - r1;
            return {8'h00, r1, r0};
        end
        return {mode, as, bs, a[3:0], a + b, a ^ b};
    endfunction

    assign {mul_carry, mul_result_1, mul_result_0} = mul_model(mul_a, mul_b, mul_a_sign, mul_b_sign, mul_mode);
    assign {w_mul_carry, w_mul_result_1, w_mul_result_0} =
        mul_model(w_mul_a, w_mul_b, w_mul_a_sign, w_mul_b_sign, w_mul_mode);

    mult_simd_job_sequencer #(.LEN_W(8), .ACC_W(48)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_a_sign(cfg_a_sign), .cfg_b_sign(cfg_b_sign), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign),
        .mul_mode(mul_mode), .mul_result_0(mul_result_0), .mul_result_1(mul_result_1),
        .mul_carry(mul_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_raw(out_raw), .out_last(out_last), .busy(busy),
        .dbg_state(dbg_state)
    );

    mult_simd_job_sequencer #(.LEN_W(8), .ACC_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(w_cfg_ready), .cfg_mode(cfg_mode),
        .cfg_a_sign(cfg_a_sign), .cfg_b_sign(cfg_b_sign), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_a_sign(w_mul_a_sign), .mul_b_sign(w_mul_b_sign),
        .mul_mode(w_mul_mode), .mul_result_0(w_mul_result_0), .mul_result_1(w_mul_result_1),
        .mul_carry(w_mul_carry), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_acc(w_out_acc), .out_raw(w_out_raw), .out_last(w_out_last), .busy(w_busy),
        .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h exp=<none>", {out_last, out_raw, out_acc});
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_raw, out_acc} !== e) begin
                    errors++;
                    $display("FAIL sb_output got=%h exp=%h", {out_last, out_raw, out_acc}, e);
                end
                checks++;
                if ({w_out_valid, w_out_last, w_out_acc} !== {1'b1, e[W-1], e[31:0]}) begin
                    errors++;
                    $display("FAIL sb_acc32 got=%h exp=%h", {w_out_valid, w_out_last, w_out_acc},
                             {1'b1, e[W-1], e[31:0]});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic start_cfg(logic [1:0] mode, logic as, logic bs, logic [7:0] len);
        int n = 0;
        @(negedge clk);
        while (!cfg_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++; errors++;
            $display("FAIL cfg_timeout got=cfg_ready_low exp=cfg_ready_high");
        end
        cfg_mode = mode; cfg_a_sign = as; cfg_b_sign = bs; cfg_len = len;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic drive_beat(logic [31:0] a, logic [31:0] b, output int stalls);
        in_valid = 1'b1; in_a = a; in_b = b;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < BUDGET) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= BUDGET) begin
            checks++; errors++;
            $display("FAIL beat_timeout got=in_ready_low exp=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drive_job(logic [1:0] mode, logic as, logic bs, int len, output int stalls);
        int st;
        start_cfg(mode, as, bs, 8'(len));
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            drive_beat(beat_a[i], beat_b[i], st);
            stalls += st;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || out_valid) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL drain got=pending:%0d exp=pending:0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if ({out_valid, out_last, out_acc, out_raw} !== '0) begin
            errors++; $display("FAIL rst_out got=%h exp=0", {out_valid, out_last, out_acc, out_raw});
        end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_signed_single();
        int st;
        beat_a[0] = 32'h0000FFFD; beat_b[0] = 32'h00000005;
        exp_q.push_back({1'b1, 72'h0, 48'hFFFFFFFFFFF1});
        drive_job(MODE_16X16, 1'b1, 1'b1, 1, st);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if ({out_valid, out_last} !== 2'b11) begin
            errors++; $display("FAIL lat_valid got=%b exp=11", {out_valid, out_last});
        end
        checks++; if (dbg_state !== HOLD) begin errors++; $display("FAIL hold_state got=%0d exp=2", dbg_state); end
        wait_drain();
    endtask

    task automatic test_unsigned_b2b();
        int st;
        beat_a[0] = 32'h0000FFFF; beat_b[0] = 32'h0000FFFF;
        beat_a[1] = 32'd2;        beat_b[1] = 32'd3;
        beat_a[2] = 32'd1;        beat_b[2] = 32'd1;
        exp_q.push_back({1'b1, 72'h0, 48'h0000FFFE0008});
        drive_job(MODE_16X16, 1'b0, 1'b0, 3, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL b2b_stalls got=%0d exp=0", st); end
        wait_drain();
    endtask

    task automatic test_simd_backpressure();
        int st;
        logic [RAW_W-1:0] snap;
        for (int i = 0; i < 4; i++) begin
            beat_a[i] = $urandom(); beat_b[i] = $urandom();
            exp_q.push_back({i == 3, mul_model(beat_a[i], beat_b[i], 1'b1, 1'b0, MODE_SUM_8X8), 48'h0});
        end
        out_ready = 1'b0;
        fork
            drive_job(MODE_SUM_8X8, 1'b1, 1'b0, 4, st);
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                snap = out_raw;
                checks++; if (snap !== mul_model(beat_a[0], beat_b[0], 1'b1, 1'b0, MODE_SUM_8X8)) begin
                    errors++; $display("FAIL bp_first got=%h exp=first_beat", snap);
                end
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks++; if ({out_valid, out_raw} !== {1'b1, snap}) begin
                        errors++; $display("FAIL bp_stable got=%h exp=%h", {out_valid, out_raw}, {1'b1, snap});
                    end
                    checks++; if (in_ready !== 1'b0) begin
                        errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_len_zero();
        exp_q.push_back({1'b1, 72'h0, 48'h0});
        start_cfg(MODE_16X16, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checks++; if ({out_valid, out_last, dbg_state} !== {2'b11, HOLD}) begin
            errors++; $display("FAIL len0_acc got=%b exp=1110", {out_valid, out_last, dbg_state});
        end
        wait_drain();
        start_cfg(MODE_SUM_2X2, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checks++; if ({busy, out_valid} !== 2'b10) begin
            errors++; $display("FAIL len0_simd_a got=%b exp=10", {busy, out_valid});
        end
        @(negedge clk);
        checks++; if ({busy, out_valid} !== 2'b00) begin
            errors++; $display("FAIL len0_simd_b got=%b exp=00", {busy, out_valid});
        end
    endtask

    task automatic test_reset_mid_job();
        int st;
        start_cfg(MODE_16X16, 1'b1, 1'b1, 8'd5);
        drive_beat(32'h0000_1234, 32'h0000_0077, st);
        drive_beat(32'h0000_8001, 32'h0000_0102, st);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({busy, in_ready, mul_a_sign, mul_b_sign, mul_mode, mul_a, mul_b} !== '0) begin
            errors++; $display("FAIL abort_ctrl got=%h exp=0", {busy, in_ready, mul_a_sign, mul_b_sign, mul_mode, mul_a, mul_b});
        end
        checks++; if ({out_valid, out_last, out_acc, out_raw} !== '0) begin
            errors++; $display("FAIL abort_out got=%h exp=0", {out_valid, out_last, out_acc, out_raw});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        beat_a[0] = 32'd3; beat_b[0] = 32'd4;
        beat_a[1] = 32'd5; beat_b[1] = 32'd6;
        exp_q.push_back({1'b1, 72'h0, 48'd42});
        drive_job(MODE_16X16, 1'b0, 1'b0, 2, st);
        wait_drain();
    endtask

    task automatic test_wrap();
        int st;
        int n = 0;
        beat_a[0] = 32'h0000FFFF; beat_b[0] = 32'h0000FFFF;
        beat_a[1] = 32'h0000FFFF; beat_b[1] = 32'h0000FFFF;
        exp_q.push_back({1'b1, 72'h0, 48'h0001FFFC0002});
        drive_job(MODE_16X16, 1'b0, 1'b0, 2, st);
        @(negedge clk);
        while (!w_out_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++; if (w_out_acc !== 32'hFFFC0002) begin
            errors++; $display("FAIL wrap32 got=%h exp=fffc0002", w_out_acc);
        end
        wait_drain();
    endtask

    task automatic test_random();
        rand_done = 1'b0;
        fork
            begin
                for (int j = 0; j < 8; j++) begin
                    logic [1:0] mode;
                    logic as, bs;
                    logic [47:0] acc;
                    int len, st;
                    mode = 2'($urandom_range(0, 3));
                    as = 1'($urandom_range(0, 1));
                    bs = 1'($urandom_range(0, 1));
                    len = $urandom_range(1, 6);
                    acc = '0;
                    for (int i = 0; i < len; i++) begin
                        beat_a[i] = $urandom(); beat_b[i] = $urandom();
                        if (mode == MODE_16X16)
                            acc += ext48(prod16(beat_a[i], beat_b[i], as, bs), as | bs);
                        else
                            exp_q.push_back({i == len - 1, mul_model(beat_a[i], beat_b[i], as, bs, mode), 48'h0});
                    end
                    if (mode == MODE_16X16) exp_q.push_back({1'b1, 72'h0, acc});
                    drive_job(mode, as, bs, len, st);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_a_sign = 1'b0; cfg_b_sign = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1;
        test_reset();
        test_signed_single();
        test_unsigned_b2b();
        test_simd_backpressure();
        test_len_zero();
        test_reset_mid_job();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
